// File: rtl/calc_pkg.sv
// Shared definitions for the calculator key encoder: widths, key type codes,
// opcode constants, error codes, FSM state encoding and the coded command word.
package calc_pkg;

    localparam int unsigned NR_W      = 4;               // operand width
    localparam int unsigned OP_W      = 4;               // opcode width
    localparam int unsigned BASE      = 10;              // multi-digit entry radix
    localparam int unsigned KEY_W     = 2;               // key type width
    localparam int unsigned DATA_W    = 4;               // key payload width
    localparam int unsigned ERR_W     = 2;               // error code width
    localparam int unsigned ACC_W     = NR_W + 4;        // accumulator compute width
    localparam int unsigned CODED_W   = OP_W + 2 * NR_W; // coded command width
    localparam int unsigned MAX_DIGIT = 9;
    localparam int unsigned MAX_OP    = 4;

    typedef enum logic [KEY_W-1:0] {
        KEY_DIGIT = 2'b00,
        KEY_OP    = 2'b01,
        KEY_EQ    = 2'b10,
        KEY_CLR   = 2'b11
    } key_type_e;

    localparam logic [OP_W-1:0] OP_NONE = OP_W'(0);
    localparam logic [OP_W-1:0] OP_ADD  = OP_W'(1);
    localparam logic [OP_W-1:0] OP_SUB  = OP_W'(2);
    localparam logic [OP_W-1:0] OP_MUL  = OP_W'(3);
    localparam logic [OP_W-1:0] OP_DIV  = OP_W'(4);

    localparam logic [ERR_W-1:0] ERR_NONE  = 2'b00;
    localparam logic [ERR_W-1:0] ERR_VALUE = 2'b01; // bad digit or opcode
    localparam logic [ERR_W-1:0] ERR_OVF   = 2'b10; // operand overflow
    localparam logic [ERR_W-1:0] ERR_SEQ   = 2'b11; // key not legal in this state

    typedef enum logic [1:0] {
        S_FIRST  = 2'd0,
        S_SECOND = 2'd1,
        S_SEND   = 2'd2
    } state_e;

    // Command word as consumed by the ALU: {op, b, a}.
    typedef struct packed {
        logic [OP_W-1:0] op;
        logic [NR_W-1:0] b;
        logic [NR_W-1:0] a;
    } coded_t;

endpackage

// File: rtl/calc_key_encoder_if.sv
// Key-event input and coded-command output handshakes of the key encoder.
//   key_valid/key_type/key_data/key_ready : key event stream from the keypad scanner
//   nr_coded/coded_valid/coded_ready      : coded command towards the ALU
//   err_pulse/err_code                    : key rejection reporting
// master = keypad/consumer side, slave = encoder side.
interface calc_key_encoder_if;
    import calc_pkg::*;

    logic              key_valid;
    logic [KEY_W-1:0]  key_type;
    logic [DATA_W-1:0] key_data;
    logic              key_ready;
    coded_t            nr_coded;
    logic              coded_valid;
    logic              coded_ready;
    logic              err_pulse;
    logic [ERR_W-1:0]  err_code;

    modport master (
        output key_valid, key_type, key_data, coded_ready,
        input  key_ready, nr_coded, coded_valid, err_pulse, err_code
    );

    modport slave (
        input  key_valid, key_type, key_data, coded_ready,
        output key_ready, nr_coded, coded_valid, err_pulse, err_code
    );

endinterface

// File: rtl/calc_digit_acc.sv
// Combinational multi-digit accumulator: sum = value*BASE + digit with overflow flag.
//   value_i : current operand
//   digit_i : new digit (range checked by the caller)
//   sum_o   : low NR_W bits of the new operand
//   ovf_o   : new operand does not fit in NR_W bits
module calc_digit_acc
    import calc_pkg::*;
(
    input  logic [NR_W-1:0]   value_i,
    input  logic [DATA_W-1:0] digit_i,
    output logic [NR_W-1:0]   sum_o,
    output logic              ovf_o
);

    logic [ACC_W-1:0] wide;

    // Wide enough for (2^NR_W-1)*BASE + 9, so the overflow test is exact.
    assign wide  = ACC_W'(value_i) * ACC_W'(BASE) + ACC_W'(digit_i);
    assign sum_o = wide[NR_W-1:0];
    assign ovf_o = |wide[ACC_W-1:NR_W];

endmodule

// File: rtl/calc_key_encoder.sv
// Key encoder: assembles digit/operator/equals/clear key events into the coded
// command word {op, b, a} and offers it on a valid/ready handshake.
//   clk  : system clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : slave side of calc_key_encoder_if (key input, coded output, errors)
module calc_key_encoder
    import calc_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    calc_key_encoder_if.slave    bus
);

    state_e           state_q, state_d;
    logic [NR_W-1:0]  a_q, a_d;
    logic [NR_W-1:0]  b_q, b_d;
    logic [OP_W-1:0]  op_q, op_d;
    logic             b_seen_q, b_seen_d;
    coded_t           nr_coded_q, nr_coded_d;
    logic             coded_valid_q, coded_valid_d;
    logic             err_pulse_q, err_pulse_d;
    logic [ERR_W-1:0] err_code_q, err_code_d;
    logic             key_ready_q, key_ready_d;

    logic             key_fire;
    logic             digit_ok;
    logic             op_ok;
    logic             send_done;
    logic [NR_W-1:0]  a_sum, b_sum;
    logic             a_ovf, b_ovf;
    logic             rej;
    logic [ERR_W-1:0] rej_code;

    assign key_fire  = bus.key_valid && key_ready_q;
    assign digit_ok  = bus.key_data <= DATA_W'(MAX_DIGIT);
    assign op_ok     = (bus.key_data != DATA_W'(0)) && (bus.key_data <= DATA_W'(MAX_OP));
    assign send_done = coded_valid_q && bus.coded_ready;

    calc_digit_acc u_acc_a (
        .value_i (a_q),
        .digit_i (bus.key_data),
        .sum_o   (a_sum),
        .ovf_o   (a_ovf)
    );

    calc_digit_acc u_acc_b (
        .value_i (b_q),
        .digit_i (bus.key_data),
        .sum_o   (b_sum),
        .ovf_o   (b_ovf)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_FIRST;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FIRST: begin
                if (key_fire && (key_type_e'(bus.key_type) == KEY_OP) && op_ok) begin
                    state_d = S_SECOND;
                end
            end
            S_SECOND: begin
                if (key_fire) begin
                    if ((key_type_e'(bus.key_type) == KEY_EQ) && b_seen_q) begin
                        state_d = S_SEND;
                    end else if (key_type_e'(bus.key_type) == KEY_CLR) begin
                        state_d = S_FIRST;
                    end
                end
            end
            S_SEND: begin
                if (send_done) begin
                    state_d = S_FIRST;
                end
            end
            default: state_d = S_FIRST;
        endcase
    end

    // Datapath and output next values
    always_comb begin
        a_d           = a_q;
        b_d           = b_q;
        op_d          = op_q;
        b_seen_d      = b_seen_q;
        nr_coded_d    = nr_coded_q;
        coded_valid_d = coded_valid_q;
        rej           = 1'b0;
        rej_code      = ERR_NONE;

        case (state_q)
            S_FIRST: begin
                if (key_fire) begin
                    case (key_type_e'(bus.key_type))
                        KEY_DIGIT: begin
                            if (!digit_ok) begin
                                rej = 1'b1; rej_code = ERR_VALUE;
                            end else if (a_ovf) begin
                                rej = 1'b1; rej_code = ERR_OVF;
                            end else begin
                                a_d = a_sum;
                            end
                        end
                        KEY_OP: begin
                            if (op_ok) begin
                                op_d = OP_W'(bus.key_data);
                            end else begin
                                rej = 1'b1; rej_code = ERR_VALUE;
                            end
                        end
                        KEY_EQ: begin
                            rej = 1'b1; rej_code = ERR_SEQ;
                        end
                        KEY_CLR: begin
                            a_d      = '0;
                            b_d      = '0;
                            op_d     = OP_NONE;
                            b_seen_d = 1'b0;
                        end
                        default: ;
                    endcase
                end
            end
            S_SECOND: begin
                if (key_fire) begin
                    case (key_type_e'(bus.key_type))
                        KEY_DIGIT: begin
                            if (!digit_ok) begin
                                rej = 1'b1; rej_code = ERR_VALUE;
                            end else if (b_ovf) begin
                                rej = 1'b1; rej_code = ERR_OVF;
                            end else begin
                                b_d      = b_sum;
                                b_seen_d = 1'b1;
                            end
                        end
                        KEY_OP: begin
                            // Operator may only be replaced before any b digit.
                            if (!op_ok) begin
                                rej = 1'b1; rej_code = ERR_VALUE;
                            end else if (b_seen_q) begin
                                rej = 1'b1; rej_code = ERR_SEQ;
                            end else begin
                                op_d = OP_W'(bus.key_data);
                            end
                        end
                        KEY_EQ: begin
                            if (b_seen_q) begin
                                nr_coded_d    = '{op: op_q, b: b_q, a: a_q};
                                coded_valid_d = 1'b1;
                            end else begin
                                rej = 1'b1; rej_code = ERR_SEQ;
                            end
                        end
                        KEY_CLR: begin
                            a_d      = '0;
                            b_d      = '0;
                            op_d     = OP_NONE;
                            b_seen_d = 1'b0;
                        end
                        default: ;
                    endcase
                end
            end
            S_SEND: begin
                if (send_done) begin
                    coded_valid_d = 1'b0;
                    a_d           = '0;
                    b_d           = '0;
                    op_d          = OP_NONE;
                    b_seen_d      = 1'b0;
                end
            end
            default: ;
        endcase

        err_pulse_d = rej;
        err_code_d  = rej ? rej_code : err_code_q;
        // Registered from next state so it tracks the state with no extra cycle.
        key_ready_d = (state_d != S_SEND);
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q           <= '0;
            b_q           <= '0;
            op_q          <= OP_NONE;
            b_seen_q      <= 1'b0;
            nr_coded_q    <= '0;
            coded_valid_q <= 1'b0;
            err_pulse_q   <= 1'b0;
            err_code_q    <= ERR_NONE;
            key_ready_q   <= 1'b1;
        end else begin
            a_q           <= a_d;
            b_q           <= b_d;
            op_q          <= op_d;
            b_seen_q      <= b_seen_d;
            nr_coded_q    <= nr_coded_d;
            coded_valid_q <= coded_valid_d;
            err_pulse_q   <= err_pulse_d;
            err_code_q    <= err_code_d;
            key_ready_q   <= key_ready_d;
        end
    end

    assign bus.key_ready   = key_ready_q;
    assign bus.nr_coded    = nr_coded_q;
    assign bus.coded_valid = coded_valid_q;
    assign bus.err_pulse   = err_pulse_q;
    assign bus.err_code    = err_code_q;

endmodule

// File: tb/tb_calc_key_encoder.sv
// Directed bench for calc_key_encoder: key sequences with hand-computed command words.
module tb_calc_key_encoder;
    import calc_pkg::*;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    calc_key_encoder_if bus();

    calc_key_encoder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One key: asserted for one cycle once key_ready is seen; outputs valid on return.
    task automatic press(input logic [1:0] t, input logic [3:0] d);
        int waited;
        @(negedge clk);
        waited = 0;
        while (!bus.key_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 20) begin
            total++; bad++;
            $display("FAIL press_timeout key_ready=%0b required=1", bus.key_ready);
        end
        bus.key_valid = 1'b1;
        bus.key_type  = t;
        bus.key_data  = d;
        @(negedge clk);
        bus.key_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.key_valid   = 1'b0;
        bus.key_type    = 2'b00;
        bus.key_data    = 4'd0;
        bus.coded_ready = 1'b1;
        #12;
        total++; if (bus.key_ready !== 1'b1) begin bad++; $display("FAIL rst_key_ready got=%0b exp=1", bus.key_ready); end
        total++; if (bus.coded_valid !== 1'b0) begin bad++; $display("FAIL rst_coded_valid got=%0b exp=0", bus.coded_valid); end
        total++; if (bus.nr_coded !== 12'h000) begin bad++; $display("FAIL rst_nr_coded got=%h exp=000", bus.nr_coded); end
        total++; if (bus.err_pulse !== 1'b0) begin bad++; $display("FAIL rst_err_pulse got=%0b exp=0", bus.err_pulse); end
        total++; if (bus.err_code !== 2'b00) begin bad++; $display("FAIL rst_err_code got=%0b exp=00", bus.err_code); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_basic_add();
        press(2'b00, 4'd1);
        press(2'b00, 4'd2);
        press(2'b01, 4'd1);
        press(2'b00, 4'd3);
        press(2'b10, 4'd0);
        total++; if (bus.coded_valid !== 1'b1) begin bad++; $display("FAIL add_valid got=%0b exp=1", bus.coded_valid); end
        total++; if (bus.nr_coded !== 12'h13C) begin bad++; $display("FAIL add_word got=%h exp=13c", bus.nr_coded); end
        total++; if (bus.key_ready !== 1'b0) begin bad++; $display("FAIL add_ready_send got=%0b exp=0", bus.key_ready); end
        @(negedge clk);
        total++; if (bus.coded_valid !== 1'b0) begin bad++; $display("FAIL add_valid_drop got=%0b exp=0", bus.coded_valid); end
        total++; if (bus.key_ready !== 1'b1) begin bad++; $display("FAIL add_ready_back got=%0b exp=1", bus.key_ready); end
    endtask

    task automatic test_overflow();
        press(2'b00, 4'd2);
        press(2'b00, 4'd5);
        total++; if (bus.err_pulse !== 1'b1) begin bad++; $display("FAIL ovf_pulse got=%0b exp=1", bus.err_pulse); end
        total++; if (bus.err_code !== 2'b10) begin bad++; $display("FAIL ovf_code got=%0b exp=10", bus.err_code); end
        @(negedge clk);
        total++; if (bus.err_pulse !== 1'b0) begin bad++; $display("FAIL ovf_pulse_len got=%0b exp=0", bus.err_pulse); end
        total++; if (bus.err_code !== 2'b10) begin bad++; $display("FAIL ovf_code_hold got=%0b exp=10", bus.err_code); end
        press(2'b01, 4'd2);
        press(2'b00, 4'd1);
        press(2'b10, 4'd0);
        total++; if (bus.nr_coded !== 12'h212) begin bad++; $display("FAIL ovf_word got=%h exp=212", bus.nr_coded); end
        total++; if (bus.coded_valid !== 1'b1) begin bad++; $display("FAIL ovf_valid got=%0b exp=1", bus.coded_valid); end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        bus.coded_ready = 1'b0;
        press(2'b00, 4'd7);
        press(2'b01, 4'd3);
        press(2'b00, 4'd2);
        press(2'b10, 4'd0);
        // Invalid digit offered while stalled: consuming it would raise err_pulse.
        for (int i = 0; i < 5; i++) begin
            bus.key_valid = 1'b1;
            bus.key_type  = 2'b00;
            bus.key_data  = 4'd12;
            total++; if (bus.coded_valid !== 1'b1) begin bad++; $display("FAIL bp_valid cyc=%0d got=%0b exp=1", i, bus.coded_valid); end
            total++; if (bus.nr_coded !== 12'h327) begin bad++; $display("FAIL bp_word cyc=%0d got=%h exp=327", i, bus.nr_coded); end
            total++; if (bus.key_ready !== 1'b0) begin bad++; $display("FAIL bp_ready cyc=%0d got=%0b exp=0", i, bus.key_ready); end
            total++; if (bus.err_pulse !== 1'b0) begin bad++; $display("FAIL bp_no_take cyc=%0d got=%0b exp=0", i, bus.err_pulse); end
            @(negedge clk);
        end
        bus.key_valid   = 1'b0;
        bus.coded_ready = 1'b1;
        @(negedge clk);
        total++; if (bus.coded_valid !== 1'b0) begin bad++; $display("FAIL bp_accept got=%0b exp=0", bus.coded_valid); end
        total++; if (bus.key_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_back got=%0b exp=1", bus.key_ready); end
        total++; if (bus.err_pulse !== 1'b0) begin bad++; $display("FAIL bp_no_take_end got=%0b exp=0", bus.err_pulse); end
    endtask

    task automatic test_sequence_err();
        press(2'b00, 4'd4);
        press(2'b10, 4'd0);
        total++; if (bus.err_code !== 2'b11) begin bad++; $display("FAIL seq_eq_first got=%0b exp=11", bus.err_code); end
        total++; if (bus.err_pulse !== 1'b1) begin bad++; $display("FAIL seq_eq_pulse got=%0b exp=1", bus.err_pulse); end
        press(2'b00, 4'd4);
        total++; if (bus.err_code !== 2'b10) begin bad++; $display("FAIL seq_44_ovf got=%0b exp=10", bus.err_code); end
        press(2'b01, 4'd1);
        press(2'b01, 4'd2);
        total++; if (bus.err_pulse !== 1'b0) begin bad++; $display("FAIL seq_op_replace got=%0b exp=0", bus.err_pulse); end
        press(2'b00, 4'd9);
        press(2'b10, 4'd0);
        total++; if (bus.nr_coded !== 12'h294) begin bad++; $display("FAIL seq_word got=%h exp=294", bus.nr_coded); end
        @(negedge clk);
    endtask

    task automatic test_clear_and_values();
        press(2'b00, 4'd9);
        press(2'b01, 4'd1);
        press(2'b00, 4'd3);
        press(2'b11, 4'd0);
        total++; if (bus.key_ready !== 1'b1) begin bad++; $display("FAIL clr_ready got=%0b exp=1", bus.key_ready); end
        press(2'b00, 4'd1);
        press(2'b01, 4'd4);
        press(2'b00, 4'd1);
        press(2'b10, 4'd0);
        total++; if (bus.nr_coded !== 12'h411) begin bad++; $display("FAIL clr_word got=%h exp=411", bus.nr_coded); end
        @(negedge clk);
        press(2'b00, 4'd12);
        total++; if (bus.err_code !== 2'b01) begin bad++; $display("FAIL bad_digit got=%0b exp=01", bus.err_code); end
        total++; if (bus.err_pulse !== 1'b1) begin bad++; $display("FAIL bad_digit_pulse got=%0b exp=1", bus.err_pulse); end
        press(2'b10, 4'd0);
        total++; if (bus.err_code !== 2'b11) begin bad++; $display("FAIL eq_after_bad got=%0b exp=11", bus.err_code); end
        press(2'b01, 4'd7);
        total++; if (bus.err_code !== 2'b01) begin bad++; $display("FAIL bad_op got=%0b exp=01", bus.err_code); end
        total++; if (bus.err_pulse !== 1'b1) begin bad++; $display("FAIL bad_op_pulse got=%0b exp=1", bus.err_pulse); end
        press(2'b01, 4'd0);
        total++; if (bus.err_code !== 2'b01) begin bad++; $display("FAIL op_zero got=%0b exp=01", bus.err_code); end
    endtask

    task automatic test_reset_in_send();
        bus.coded_ready = 1'b0;
        press(2'b00, 4'd1);
        press(2'b00, 4'd2);
        press(2'b01, 4'd1);
        press(2'b00, 4'd3);
        press(2'b10, 4'd0);
        total++; if (bus.nr_coded !== 12'h13C) begin bad++; $display("FAIL rs_word got=%h exp=13c", bus.nr_coded); end
        total++; if (bus.err_code !== 2'b01) begin bad++; $display("FAIL rs_err_before got=%0b exp=01", bus.err_code); end
        #2 rst = 1'b0;
        #1;
        total++; if (bus.coded_valid !== 1'b0) begin bad++; $display("FAIL rs_valid got=%0b exp=0", bus.coded_valid); end
        total++; if (bus.nr_coded !== 12'h000) begin bad++; $display("FAIL rs_word_clr got=%h exp=000", bus.nr_coded); end
        total++; if (bus.err_code !== 2'b00) begin bad++; $display("FAIL rs_err_clr got=%0b exp=00", bus.err_code); end
        @(negedge clk);
        rst = 1'b1;
        bus.coded_ready = 1'b1;
        @(negedge clk);
        total++; if (bus.key_ready !== 1'b1) begin bad++; $display("FAIL rs_ready got=%0b exp=1", bus.key_ready); end
        total++; if (bus.coded_valid !== 1'b0) begin bad++; $display("FAIL rs_no_emit got=%0b exp=0", bus.coded_valid); end
        press(2'b00, 4'd5);
        press(2'b01, 4'd3);
        press(2'b00, 4'd5);
        press(2'b10, 4'd0);
        total++; if (bus.nr_coded !== 12'h355) begin bad++; $display("FAIL rs_fresh got=%h exp=355", bus.nr_coded); end
        @(negedge clk);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_basic_add();
        test_overflow();
        test_backpressure();
        test_sequence_err();
        test_clear_and_values();
        test_reset_in_send();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
